// File: rtl/mem_initiator_pkg.sv
// Shared definitions for the data-memory requester: op codes, FSM states, default widths.
package mem_initiator_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_COPY  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

endpackage

// File: rtl/mem_initiator.sv
// Requester-side sequencer for the 8-bit data memory port. Runs LOAD, STORE and
// byte-by-byte forward COPY requests; the memory writes on the falling edge and
// reads combinationally while memLoad is high. Every output is a flop.
import mem_initiator_pkg::*;

module mem_initiator #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_dst,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          memWrite,
  output logic          memLoad,
  output logic [AW-1:0] endereco,
  output logic [DW-1:0] dadoEscr,
  input  logic [DW-1:0] dadoLido
);

  state_e        state;
  op_e           op_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] idx;
  logic [DW-1:0] data_q;
  logic [DW-1:0] buf_q;

  // FSM plus datapath registers; strobes and rsp_valid default low so they are
  // single-cycle pulses. Responses are issued on the transition back to IDLE,
  // so RESP is never entered and only falls back to IDLE if ever reached.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= OP_LOAD;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx       <= '0;
      data_q    <= '0;
      buf_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      memWrite  <= 1'b0;
      memLoad   <= 1'b0;
      endereco  <= '0;
      dadoEscr  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      memLoad   <= 1'b0;
      memWrite  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q   <= op_e'(req_op);
            src_q  <= req_addr;
            dst_q  <= req_dst;
            data_q <= req_data;
            len_q  <= AW'(req_data);
            idx    <= '0;
            case (op_e'(req_op))
              OP_LOAD: begin
                state     <= RD;
                memLoad   <= 1'b1;
                endereco  <= req_addr;
                req_ready <= 1'b0;
              end
              OP_STORE: begin
                state     <= WR;
                memWrite  <= 1'b1;
                endereco  <= req_addr;
                dadoEscr  <= req_data;
                req_ready <= 1'b0;
              end
              OP_COPY: begin
                // zero-length copy completes at once and leaves rsp_data alone
                if (req_data == '0) begin
                  rsp_valid <= 1'b1;
                end else begin
                  state     <= RD;
                  memLoad   <= 1'b1;
                  endereco  <= req_addr;
                  req_ready <= 1'b0;
                end
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
              end
            endcase
          end
        end
        RD: begin
          if (op_q == OP_LOAD) begin
            rsp_data  <= dadoLido;
            rsp_valid <= 1'b1;
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            buf_q    <= dadoLido;
            state    <= WR;
            memWrite <= 1'b1;
            endereco <= dst_q + idx;
            dadoEscr <= dadoLido;
          end
        end
        WR: begin
          if (op_q == OP_STORE) begin
            rsp_data  <= data_q;
            rsp_valid <= 1'b1;
            state     <= IDLE;
            req_ready <= 1'b1;
          end else if (idx == len_q - 1'b1) begin
            rsp_data  <= buf_q;
            rsp_valid <= 1'b1;
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            idx      <= idx + 1'b1;
            state    <= RD;
            memLoad  <= 1'b1;
            endereco <= src_q + idx + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
